// File: rtl/thermo_setpoint_ctrl.sv
// Thermostat set-point controller: conditions the operator controls, holds the set point,
// tracks the latest DHT11 reading and drives match/heat/cool/stale and the display value.
module thermo_setpoint_ctrl #(
  parameter int unsigned DEBOUNCE_CYC = 1_000_000,
  parameter int unsigned STALE_CYC    = 150_000_000,
  parameter logic [7:0]  SP_MIN       = 8'd0,
  parameter logic [7:0]  SP_MAX       = 8'd50,
  parameter logic [7:0]  SP_RESET     = 8'd25,
  parameter logic [7:0]  HYST         = 8'd1
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [7:0] temp_i,
  input  logic       temp_vld_i,
  input  logic       mode_switch,
  input  logic       btn_inc,
  input  logic       btn_dec,
  output logic [7:0] setpoint_o,
  output logic [7:0] disp_val_o,
  output logic       set_mode_o,
  output logic       LED_match,
  output logic       heat_o,
  output logic       cool_o,
  output logic       stale_o
);

  localparam int DB_W    = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int STALE_W = (STALE_CYC > 1) ? $clog2(STALE_CYC) : 1;
  localparam logic [DB_W-1:0]    DB_LAST    = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [STALE_W-1:0] STALE_LAST = STALE_W'(STALE_CYC - 1);

  typedef enum logic {
    ST_READ = 1'b0,
    ST_SET  = 1'b1
  } state_t;

  // Index map for the conditioned inputs: 0 = mode switch, 1 = inc, 2 = dec.
  logic [2:0]      raw;
  logic [2:0]      sync1_q;
  logic [2:0]      sync2_q;
  logic [2:0]      deb_q;
  logic [DB_W-1:0] db_cnt_q [3];

  // Button edge detection; bit 0 = inc, bit 1 = dec.
  logic [1:0] btn_deb_d_q;
  logic [1:0] btn_armed_q;
  logic       inc_pulse;
  logic       dec_pulse;

  state_t state_q;
  state_t state_d;

  logic [7:0]         temp_q;
  logic               have_sample_q;
  logic [STALE_W-1:0] stale_cnt_q;

  logic       ok;
  logic [8:0] temp9;
  logic [8:0] sp9;
  logic [8:0] hyst9;

  assign raw = {btn_dec, btn_inc, mode_switch};

  // Synchronise, then accept a new level only after DEBOUNCE_CYC consecutive cycles of it.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      for (int i = 0; i < 3; i++) begin
        db_cnt_q[i] <= '0;
      end
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      for (int i = 0; i < 3; i++) begin
        if (sync2_q[i] == deb_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DB_LAST) begin
          deb_q[i]    <= sync2_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // A button is armed only once it has been seen released since reset,
  // so a press held through reset never produces a step.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      btn_deb_d_q <= '0;
      btn_armed_q <= '0;
    end else begin
      btn_deb_d_q <= deb_q[2:1];
      if (!sync2_q[1]) btn_armed_q[0] <= 1'b1;
      if (!sync2_q[2]) btn_armed_q[1] <= 1'b1;
    end
  end

  assign inc_pulse = deb_q[1] & ~btn_deb_d_q[0] & btn_armed_q[0];
  assign dec_pulse = deb_q[2] & ~btn_deb_d_q[1] & btn_armed_q[1];

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= ST_READ;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_READ: if (deb_q[0])  state_d = ST_SET;
      ST_SET:  if (!deb_q[0]) state_d = ST_READ;
      default: state_d = ST_READ;
    endcase
  end

  assign set_mode_o = (state_q == ST_SET);

  // Saturating edit; simultaneous inc and dec cancel out.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      setpoint_o <= SP_RESET;
    end else if ((state_q == ST_SET) && (inc_pulse ^ dec_pulse)) begin
      if (inc_pulse) begin
        setpoint_o <= (setpoint_o >= SP_MAX) ? SP_MAX : setpoint_o + 8'd1;
      end else begin
        setpoint_o <= (setpoint_o <= SP_MIN) ? SP_MIN : setpoint_o - 8'd1;
      end
    end
  end

  // temp_vld_i is a single-cycle strobe with no back-pressure: a reading is taken
  // on every cycle it is high, and a strobe beats a coincident timeout.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      temp_q        <= '0;
      have_sample_q <= 1'b0;
      stale_cnt_q   <= '0;
      stale_o       <= 1'b1;
    end else if (temp_vld_i) begin
      temp_q        <= temp_i;
      have_sample_q <= 1'b1;
      stale_cnt_q   <= '0;
      stale_o       <= 1'b0;
    end else if (stale_cnt_q == STALE_LAST) begin
      have_sample_q <= 1'b0;
      stale_o       <= 1'b1;
    end else begin
      stale_cnt_q <= stale_cnt_q + 1'b1;
    end
  end

  assign ok    = have_sample_q & ~stale_o;
  assign temp9 = {1'b0, temp_q};
  assign sp9   = {1'b0, setpoint_o};
  assign hyst9 = {1'b0, HYST};

  // temp < sp-HYST is evaluated as temp+HYST < sp so a small set point cannot wrap.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      LED_match <= 1'b0;
      heat_o    <= 1'b0;
      cool_o    <= 1'b0;
    end else begin
      LED_match <= ok & (temp_q == setpoint_o);
      if (!ok || (temp9 >= sp9)) begin
        heat_o <= 1'b0;
      end else if ((temp9 + hyst9) < sp9) begin
        heat_o <= 1'b1;
      end
      if (!ok || (temp9 <= sp9)) begin
        cool_o <= 1'b0;
      end else if (temp9 > (sp9 + hyst9)) begin
        cool_o <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      disp_val_o <= '0;
    end else if (state_q == ST_SET) begin
      disp_val_o <= setpoint_o;
    end else begin
      disp_val_o <= have_sample_q ? temp_q : 8'd0;
    end
  end

endmodule
